fetch_mt_queue: RTL and testbench

//  Parametrised multithreaded fetch front-end. Holds per-thread PCs, issues fetch requests round-robin to an

---
 rtl/fetch_mt_queue.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_fetch_mt_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mt_queue.sv
// fetch_mt_queue -- multithreaded fetch front-end.
//
// Keeps one PC per hardware thread and issues fetch requests round-robin
// over the eligible threads. Each thread has at most one request in flight.
// Tagged responses are buffered in per-thread instruction queues. One
// instruction per cycle is popped round-robin over the non-stalled threads
// and presented to decode on registered outputs. A branch redirect reloads
// the thread PC, flushes its queue and discards its in-flight response.
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   boot_addr             PC loaded into every thread while in reset
//   thread_en             thread may start new fetch requests
//   take_branch/branch_pc per-thread redirect pulse and target
//   stall_fetch           decode cannot accept thread t this cycle
//   req_*                 fetch request (valid/ready), held stable until accepted
//   rsp_*                 fetch response, at most one per request, in order per thread
//   decode_*              registered instruction output to decode
//   perf_issued           per-thread saturating pop counters
//                         (present only when FETCH_PERF_CNT_EN is defined)
//
// Build option: FETCH_PERF_CNT_EN adds the perf_issued output and its counters.

// Per-thread circular instruction queue. Flush empties it in one cycle.
// Push and pop may happen in the same cycle; the owner never pushes into a
// full queue (request credit accounts for the in-flight slot).
module fetch_mt_tq #(
    parameter int DEPTH = 4,
    parameter int ENT_W = 66,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [ENT_W-1:0] push_data,
    output logic [ENT_W-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ENT_W-1:0] mem;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            wr_ptr;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

module fetch_mt_queue #(
    parameter  int NUM_THREADS = 4,
    parameter  int PC_WIDTH    = 32,
    parameter  int INSTR_WIDTH = 32,
    parameter  int FBUF_DEPTH  = 4,
    parameter  int XCPT_WIDTH  = 2,
    localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [PC_WIDTH-1:0]             boot_addr,
    input  logic [NUM_THREADS-1:0]          thread_en,
    input  logic [NUM_THREADS-1:0]          take_branch,
    input  logic [NUM_THREADS*PC_WIDTH-1:0] branch_pc,
    input  logic [NUM_THREADS-1:0]          stall_fetch,
    output logic                            req_valid,
    input  logic                            req_ready,
    output logic [PC_WIDTH-1:0]             req_addr,
    output logic [TID_W-1:0]                req_thread_id,
    input  logic                            rsp_valid,
    input  logic [TID_W-1:0]                rsp_thread_id,
    input  logic [INSTR_WIDTH-1:0]          rsp_data,
    input  logic [XCPT_WIDTH-1:0]           rsp_xcpt,
    output logic                            decode_valid,
    output logic [INSTR_WIDTH-1:0]          decode_instr,
    output logic [PC_WIDTH-1:0]             decode_pc,
    output logic [TID_W-1:0]                decode_thread_id,
    output logic [XCPT_WIDTH-1:0]           decode_xcpt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [NUM_THREADS*32-1:0]       perf_issued
`endif
);
    localparam int CNT_W = $clog2(FBUF_DEPTH + 1);
    localparam int ENT_W = INSTR_WIDTH + PC_WIDTH + XCPT_WIDTH;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        logic [XCPT_WIDTH-1:0]  xcpt;
    } fbuf_ent_t;

    // First set bit of vec at or after ptr, wrapping modulo NUM_THREADS.
    function automatic logic [TID_W-1:0] rr_pick(input logic [NUM_THREADS-1:0] vec,
                                                  input logic [TID_W-1:0]       ptr);
        logic [TID_W-1:0] sel;
        sel = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (vec[(int'(ptr) + i) % NUM_THREADS]) sel = TID_W'((int'(ptr) + i) % NUM_THREADS);
        end
        return sel;
    endfunction

    function automatic logic [TID_W-1:0] rr_next(input logic [TID_W-1:0] t);
        return (int'(t) == NUM_THREADS - 1) ? '0 : t + TID_W'(1);
    endfunction

    logic [NUM_THREADS-1:0][PC_WIDTH-1:0] pc;
    logic [NUM_THREADS-1:0][ENT_W-1:0]    head;
    logic [NUM_THREADS-1:0][CNT_W-1:0]    count;
    logic [NUM_THREADS-1:0]               inflight;
    logic [NUM_THREADS-1:0]               elig;
    logic [NUM_THREADS-1:0]               cand;
    logic [NUM_THREADS-1:0]               hs_vec;
    logic [NUM_THREADS-1:0]               pop;

    logic [TID_W-1:0]    req_ptr;
    logic [TID_W-1:0]    dec_ptr;
    logic [TID_W-1:0]    grant;
    logic [TID_W-1:0]    dec_pick;
    logic                pop_any;
    logic                hs;
    logic [PC_WIDTH-1:0] grant_addr;
    fbuf_ent_t           pop_ent;

    // A request seen without ready is frozen here until it is accepted.
    // lock_stale marks that the locked thread was redirected meanwhile, so
    // the request goes out as issued but its response is discarded.
    logic                lock_vld;
    logic                lock_stale;
    logic [TID_W-1:0]    lock_tid;
    logic [PC_WIDTH-1:0] lock_addr;

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            elig[t] = thread_en[t] & ~inflight[t] & ~take_branch[t]
                    & (int'(count[t]) < FBUF_DEPTH);
            cand[t] = (count[t] != '0) & ~stall_fetch[t] & ~take_branch[t];
        end
    end

    assign grant      = lock_vld ? lock_tid : rr_pick(elig, req_ptr);
    assign grant_addr = lock_vld ? lock_addr : pc[grant];
    // Gated by reset so the outputs are 0 the moment reset asserts.
    assign req_valid     = reset & (lock_vld | (|elig));
    assign req_addr      = req_valid ? grant_addr : '0;
    assign req_thread_id = req_valid ? grant : '0;
    assign hs            = req_valid & req_ready;

    assign pop_any  = |cand;
    assign dec_pick = rr_pick(cand, dec_ptr);
    assign pop_ent  = fbuf_ent_t'(head[dec_pick]);

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        logic [PC_WIDTH-1:0] pc_q;
        logic [PC_WIDTH-1:0] ipc_q;   // address of the request now in flight
        logic                infl_q;
        logic                drop_q;
        logic                halt_q;
        logic                rsp_hit;
        logic                push;
        logic                stale_hs;

        assign hs_vec[t]   = hs & (grant == TID_W'(t));
        assign pop[t]      = pop_any & (dec_pick == TID_W'(t));
        assign rsp_hit     = rsp_valid & (rsp_thread_id == TID_W'(t)) & infl_q;
        assign push        = rsp_hit & ~drop_q & ~take_branch[t];
        assign stale_hs    = hs_vec[t] & lock_vld & lock_stale;
        assign pc[t]       = pc_q;
        assign inflight[t] = infl_q | halt_q;   // halt blocks requests like an outstanding one

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                pc_q   <= boot_addr;
                ipc_q  <= '0;
                infl_q <= 1'b0;
                drop_q <= 1'b0;
                halt_q <= 1'b0;
            end else begin
                if (hs_vec[t]) begin
                    infl_q <= 1'b1;
                    ipc_q  <= grant_addr;
                end else if (rsp_hit) begin
                    infl_q <= 1'b0;
                end

                if (take_branch[t]) begin
                    pc_q   <= branch_pc[t*PC_WIDTH +: PC_WIDTH];
                    halt_q <= 1'b0;
                    // A response arriving this cycle is simply discarded; only
                    // a request still outstanding afterwards must be dropped.
                    drop_q <= hs_vec[t] | (infl_q & ~rsp_hit);
                end else begin
                    if (hs_vec[t] && !stale_hs) pc_q <= pc_q + PC_WIDTH'(4);
                    if (stale_hs)                drop_q <= 1'b1;
                    else if (rsp_hit && drop_q)  drop_q <= 1'b0;
                    if (push && rsp_xcpt != '0)  halt_q <= 1'b1;
                end
            end
        end

        fetch_mt_tq #(
            .DEPTH (FBUF_DEPTH),
            .ENT_W (ENT_W),
            .CNT_W (CNT_W)
        ) u_tq (
            .clock     (clock),
            .reset     (reset),
            .flush     (take_branch[t]),
            .push      (push),
            .pop       (pop[t]),
            .push_data ({rsp_data, ipc_q, rsp_xcpt}),
            .head      (head[t]),
            .count     (count[t])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ptr          <= '0;
            dec_ptr          <= '0;
            lock_vld         <= 1'b0;
            lock_stale       <= 1'b0;
            lock_tid         <= '0;
            lock_addr        <= '0;
            decode_valid     <= 1'b0;
            decode_instr     <= '0;
            decode_pc        <= '0;
            decode_thread_id <= '0;
            decode_xcpt      <= '0;
        end else begin
            if (hs) begin
                req_ptr    <= rr_next(grant);
                lock_vld   <= 1'b0;
                lock_stale <= 1'b0;
            end else if (req_valid) begin
                lock_vld   <= 1'b1;
                lock_tid   <= grant;
                lock_addr  <= grant_addr;
                lock_stale <= lock_vld & (lock_stale | take_branch[lock_tid]);
            end

            decode_valid <= pop_any;
            if (pop_any) begin
                decode_instr     <= pop_ent.instr;
                decode_pc        <= pop_ent.pc;
                decode_xcpt      <= pop_ent.xcpt;
                decode_thread_id <= dec_pick;
                dec_ptr          <= rr_next(dec_pick);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [NUM_THREADS-1:0][31:0] perf_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (pop[t] && perf_q[t] != '1) perf_q[t] <= perf_q[t] + 32'd1;
            end
        end
    end

    assign perf_issued = perf_q;
`endif
endmodule

// File: tb/tb_fetch_mt_queue.sv
module tb_fetch_mt_queue;
    localparam int NT = 4;

    typedef struct packed {
        logic [1:0]  tid;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic [1:0]  tid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  xcpt;
    } dec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    boot_addr = 32'h100;
    logic [NT-1:0]  thread_en = '0;
    logic [NT-1:0]  take_branch = '0;
    logic [NT*32-1:0] branch_pc = '0;
    logic [NT-1:0]  stall_fetch = '0;
    logic           req_valid;
    logic           req_ready = 1'b1;
    logic [31:0]    req_addr;
    logic [1:0]     req_thread_id;
    logic           rsp_valid = 1'b0;
    logic [1:0]     rsp_thread_id = '0;
    logic [31:0]    rsp_data = '0;
    logic [1:0]     rsp_xcpt = '0;
    logic           decode_valid;
    logic [31:0]    decode_instr;
    logic [31:0]    decode_pc;
    logic [1:0]     decode_thread_id;
    logic [1:0]     decode_xcpt;

    int   checks = 0;
    int   errors = 0;
    req_t exp_req[$];
    dec_t exp_dec[$];
    req_t pend[$];
    logic        rsp_hold  = 1'b0;
    logic [31:0] xcpt_addr = 32'hFFFF_FFFF;

    fetch_mt_queue #(
        .NUM_THREADS (NT), .PC_WIDTH (32), .INSTR_WIDTH (32),
        .FBUF_DEPTH (4), .XCPT_WIDTH (2)
    ) dut (
        .clock (clock), .reset (reset), .boot_addr (boot_addr),
        .thread_en (thread_en), .take_branch (take_branch), .branch_pc (branch_pc),
        .stall_fetch (stall_fetch), .req_valid (req_valid), .req_ready (req_ready),
        .req_addr (req_addr), .req_thread_id (req_thread_id), .rsp_valid (rsp_valid),
        .rsp_thread_id (rsp_thread_id), .rsp_data (rsp_data), .rsp_xcpt (rsp_xcpt),
        .decode_valid (decode_valid), .decode_instr (decode_instr), .decode_pc (decode_pc),
        .decode_thread_id (decode_thread_id), .decode_xcpt (decode_xcpt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic exp_r(input logic [1:0] tid, input logic [31:0] addr);
        exp_req.push_back('{tid: tid, addr: addr});
    endtask

    task automatic exp_d(input logic [1:0] tid, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [1:0] xcpt);
        exp_dec.push_back('{tid: tid, pc: pc, instr: instr, xcpt: xcpt});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        chk({tag, "_req_addr"}, 64'(req_addr), 64'd0);
        chk({tag, "_req_tid"}, 64'(req_thread_id), 64'd0);
        chk({tag, "_dec_valid"}, 64'(decode_valid), 64'd0);
        chk({tag, "_dec_instr"}, 64'(decode_instr), 64'd0);
        chk({tag, "_dec_pc"}, 64'(decode_pc), 64'd0);
        chk({tag, "_dec_tid"}, 64'(decode_thread_id), 64'd0);
        chk({tag, "_dec_xcpt"}, 64'(decode_xcpt), 64'd0);
    endtask

    // Enter reset at a falling edge with quiet inputs, hold two rising
    // edges, release at a falling edge. Caller drives stimulus right after.
    task automatic do_reset(input logic [31:0] boot, input logic check);
        @(negedge clock);
        thread_en = '0; take_branch = '0; stall_fetch = '0; branch_pc = '0;
        req_ready = 1'b1; rsp_hold = 1'b0; xcpt_addr = 32'hFFFF_FFFF;
        boot_addr = boot;
        reset = 1'b0;
        #1;
        if (check) chk_zero_outputs("rst");
        tick(2);
        reset = 1'b1;
    endtask

    // Memory model: record accepted requests, answer one cycle later.
    initial forever begin
        @(negedge clock); #4;
        if (reset && req_valid && req_ready) pend.push_back('{tid: req_thread_id, addr: req_addr});
    end

    initial forever begin
        req_t r;
        @(negedge clock); #1;
        if (!reset) begin
            pend.delete();
            rsp_valid = 1'b0;
        end else if (!rsp_hold && pend.size() > 0) begin
            r = pend.pop_front();
            rsp_valid     = 1'b1;
            rsp_thread_id = r.tid;
            rsp_data      = r.addr ^ 32'hDEAD_0000;
            rsp_xcpt      = (r.addr == xcpt_addr) ? 2'b10 : 2'b00;
        end else begin
            rsp_valid = 1'b0;
        end
    end

    // Monitor: compares every accepted request and every decode output
    // against the heads of the expectation queues.
    initial forever begin
        req_t ra, re;
        dec_t da, de;
        @(negedge clock); #4;
        if (reset) begin
            if (req_valid && req_ready) begin
                ra = '{tid: req_thread_id, addr: req_addr};
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected actual tid=%0d addr=%0h required none", ra.tid, ra.addr);
                end else begin
                    re = exp_req.pop_front();
                    if (ra != re) begin
                        errors++;
                        $display("FAIL req actual tid=%0d addr=%0h required tid=%0d addr=%0h",
                                 ra.tid, ra.addr, re.tid, re.addr);
                    end
                end
            end
            if (decode_valid) begin
                da = '{tid: decode_thread_id, pc: decode_pc, instr: decode_instr, xcpt: decode_xcpt};
                checks++;
                if (exp_dec.size() == 0) begin
                    errors++;
                    $display("FAIL dec_unexpected actual tid=%0d pc=%0h required none", da.tid, da.pc);
                end else begin
                    de = exp_dec.pop_front();
                    if (da != de) begin
                        errors++;
                        $display("FAIL dec actual tid=%0d pc=%0h instr=%0h xcpt=%0d required tid=%0d pc=%0h instr=%0h xcpt=%0d",
                                 da.tid, da.pc, da.instr, da.xcpt, de.tid, de.pc, de.instr, de.xcpt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;

        // Single thread: sequential PCs, decoded in order.
        do_reset(32'h100, 1'b1);
        exp_r(0, 32'h100); exp_r(0, 32'h104); exp_r(0, 32'h108);
        exp_d(0, 32'h100, 32'hDEAD_0100, 0);
        exp_d(0, 32'h104, 32'hDEAD_0104, 0);
        exp_d(0, 32'h108, 32'hDEAD_0108, 0);
        thread_en = 4'b0001;
        tick(5);
        thread_en = '0;
        tick(6);

        // Four threads: requests and decode both rotate 0,1,2,3.
        do_reset(32'h100, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int t = 0; t < 4; t++) begin
                exp_r(2'(t), 32'h100 + 32'(4 * k));
                exp_d(2'(t), 32'h100 + 32'(4 * k), 32'hDEAD_0100 + 32'(4 * k), 0);
            end
        thread_en = 4'b1111;
        tick(8);
        thread_en = '0;
        tick(8);

        // Redirect while a request is in flight: its response is dropped.
        do_reset(32'h200, 1'b0);
        exp_r(0, 32'h200); exp_r(0, 32'h800);
        exp_d(0, 32'h800, 32'hDEAD_0800, 0);
        thread_en = 4'b0001; rsp_hold = 1'b1;
        tick(1);
        take_branch = 4'b0001; branch_pc[31:0] = 32'h800;
        tick(1);
        take_branch = '0; rsp_hold = 1'b0;
        tick(2);
        thread_en = '0;
        tick(6);

        // Memory not ready: the request stays frozen, even after thread_en drops.
        do_reset(32'h300, 1'b0);
        exp_r(2, 32'h300);
        exp_d(2, 32'h300, 32'hDEAD_0300, 0);
        thread_en = 4'b0100; req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("lock_valid", 64'(req_valid), 64'd1);
            chk("lock_addr", 64'(req_addr), 64'h300);
            chk("lock_tid", 64'(req_thread_id), 64'd2);
            tick(1);
            thread_en = '0;
        end
        req_ready = 1'b1;
        tick(1);
        #2 chk("after_lock_idle", 64'(req_valid), 64'd0);
        tick(6);

        // Stalled thread: queue fills to depth, then fetching stops.
        do_reset(32'h100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_r(1, 32'h100 + 32'(4 * k));
            exp_d(1, 32'h100 + 32'(4 * k), 32'hDEAD_0100 + 32'(4 * k), 0);
        end
        thread_en = 4'b0010; stall_fetch = 4'b0010;
        tick(12);
        #2 chk("full_no_req", 64'(req_valid), 64'd0);
        chk("stalled_no_dec", 64'(decode_valid), 64'd0);
        thread_en = '0;
        tick(1);
        stall_fetch = '0;
        tick(8);

        // Exception response halts the thread until the next redirect.
        do_reset(32'h3C, 1'b0);
        xcpt_addr = 32'h40;
        exp_r(0, 32'h3C); exp_r(0, 32'h40); exp_r(0, 32'h500);
        exp_d(0, 32'h3C, 32'hDEAD_003C, 0);
        exp_d(0, 32'h40, 32'hDEAD_0040, 2'b10);
        exp_d(0, 32'h500, 32'hDEAD_0500, 0);
        thread_en = 4'b0001;
        tick(10);
        #2 chk("halted_no_req", 64'(req_valid), 64'd0);
        take_branch = 4'b0001; branch_pc[31:0] = 32'h500;
        tick(1);
        take_branch = '0;
        tick(1);
        thread_en = '0;
        tick(6);

        // Reset in the middle of a four-thread burst.
        do_reset(32'h100, 1'b0);
        for (int t = 0; t < 4; t++) begin
            exp_r(2'(t), 32'h100);
            exp_d(2'(t), 32'h100, 32'hDEAD_0100, 0);
        end
        exp_r(0, 32'h104); exp_r(1, 32'h104); exp_r(2, 32'h104);
        thread_en = 4'b1111;
        tick(7);
        reset = 1'b0;
        #1 chk_zero_outputs("midrst");
        tick(2);
        boot_addr = 32'h700;
        tick(2);
        exp_r(0, 32'h700);
        exp_d(0, 32'h700, 32'hDEAD_0700, 0);
        reset = 1'b1; thread_en = 4'b0001;
        tick(1);
        thread_en = '0;
        tick(6);

        chk("req_left", 64'(exp_req.size()), 64'd0);
        chk("dec_left", 64'(exp_dec.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
